// File: rtl/instr_sequencer.sv
// Replays a small loadable program into proc over the Run/Done handshake,
// one instruction at a time, with a Done timeout.
//
// state | meaning
// IDLE  | after reset; program memory writable
// ISSUE | fetch mem[pc] onto Instruction and raise Run
// WAIT  | Run dropped, Instruction held; waiting for Done or timeout
// NEXT  | advance pc; finish when Count reaches len
// FIN   | all instructions done; Finished held until next Start
// ERR   | Done timed out; Error held until next Start
module instr_sequencer #(
  parameter int IW      = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [AW:0]   Len,
  input  logic          Start,
  input  logic          Done,
  output logic [IW-1:0] Instruction,
  output logic          Run,
  output logic          Busy,
  output logic          Finished,
  output logic          Error,
  output logic [AW:0]   Count
);

  localparam int DEPTH = 2 ** AW;
  localparam int WW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   DEPTH_L = {1'b1, {AW{1'b0}}};
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_FIN, S_ERR
  } state_t;

  state_t        state_q;
  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic [AW:0]   cnt_q;
  logic [WW-1:0] wcnt_q;
  logic [IW-1:0] instr_q;
  logic          run_q;
  logic          busy_q;
  logic          fin_q;
  logic          err_q;

  logic [AW:0]   len_clamp;
  logic [IW-1:0] mem_rd;

  // Clamping len to DEPTH means the wrapping pc never reissues a word.
  assign len_clamp = (Len > DEPTH_L) ? DEPTH_L : Len;
  assign mem_rd    = mem_q[pc_q];

  always_ff @(posedge Clock) begin
    if (prog_we && state_q == S_IDLE) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      instr_q <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      run_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_FIN, S_ERR: begin
          if (Start) begin
            fin_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            pc_q   <= '0;
            wcnt_q <= '0;
            len_q  <= len_clamp;
            if (len_clamp == '0) begin
              state_q <= S_FIN;
              fin_q   <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          instr_q <= mem_rd;
          run_q   <= 1'b1;
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Done is only looked at here, so a stale Done during ISSUE is ignored.
          if (Done) begin
            cnt_q   <= cnt_q + 1'b1;
            wcnt_q  <= '0;
            state_q <= S_NEXT;
          end else if (wcnt_q == WAIT_MAX) begin
            wcnt_q  <= '0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_NEXT: begin
          pc_q <= pc_q + 1'b1;
          if (cnt_q == len_q) begin
            fin_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Instruction = instr_q;
  assign Run         = run_q;
  assign Busy        = busy_q;
  assign Finished    = fin_q;
  assign Error       = err_q;
  assign Count       = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table of runs, scoreboard of
// expected instruction words, and hand-written timeout/reset/write-guard cases.
module tb_instr_sequencer;
  localparam int IW = 16, AW = 4, DEPTH = 16, TIMEOUT = 64;

  logic          Clock = 1'b0, Resetn = 1'b0;
  logic          prog_we = 1'b0, Start = 1'b0, Done = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [AW:0]   Len = '0;
  logic [IW-1:0] Instruction;
  logic          Run, Busy, Finished, Error;
  logic [AW:0]   Count;

  instr_sequencer #(.IW(IW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Resetn(Resetn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .Len(Len), .Start(Start), .Done(Done),
    .Instruction(Instruction), .Run(Run), .Busy(Busy), .Finished(Finished),
    .Error(Error), .Count(Count)
  );

  always #5 Clock = ~Clock;

  int checks = 0, failures = 0;
  logic [IW-1:0] mem_m [DEPTH];
  logic [IW-1:0] exp_q [$];
  int pat [3] = '{1, 3, 2};

  typedef struct {
    int len;
    int exp_runs;
    int exp_count;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a run and services Done with delays 1/3/2 cycles after each Run.
  task automatic run_prog(input int len, input int exp_runs, input int exp_count,
                          input bit poke, input bit wr0, input logic [IW-1:0] wr_data);
    int n;
    int runs = 0;
    int cd = 0;
    bit prev_run = 1'b0;
    bit ended = 1'b0;
    n = (len > DEPTH) ? DEPTH : len;
    @(negedge Clock);
    if (wr0) begin
      prog_we = 1'b1; prog_addr = '0; prog_data = wr_data;
      mem_m[0] = wr_data;
    end
    for (int i = 0; i < n; i++) exp_q.push_back(mem_m[i]);
    Len = (AW+1)'(len);
    Start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge Clock);
      Start = 1'b0; prog_we = 1'b0; Done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) Done = 1'b1;
      end
      if (Run) begin
        runs++;
        chk("run_single_cycle", {31'd0, prev_run}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_run: got Run with instr %0h expected no Run", Instruction);
        end else begin
          chk("instruction", {16'd0, Instruction}, {16'd0, exp_q.pop_front()});
        end
        cd = pat[(runs - 1) % 3];
      end
      prev_run = Run;
      if (poke && Busy) begin
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'hFFFF; Start = 1'b1;
      end
      if (Finished || Error) begin
        ended = 1'b1;
        break;
      end
    end
    Done = 1'b0; Start = 1'b0; prog_we = 1'b0;
    chk("run_ended_in_bound", {31'd0, ended}, 32'd1);
    chk("run_count", runs, exp_runs);
    chk("count_out", {27'd0, Count}, exp_count);
    chk("finished", {31'd0, Finished}, 32'd1);
    chk("error_clear", {31'd0, Error}, 32'd0);
    chk("busy_idle", {31'd0, Busy}, 32'd0);
    chk("run_low_fin", {31'd0, Run}, 32'd0);
    chk("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{3, 3, 3};
    vecs[1] = '{1, 1, 1};
    vecs[2] = '{5, 5, 5};
    vecs[3] = '{16, 16, 16};
    vecs[4] = '{20, 16, 16};
    vecs[5] = '{31, 16, 16};
    mem_m[0] = 16'h101C; mem_m[1] = 16'h32FF; mem_m[2] = 16'h52FF;
    for (int i = 3; i < DEPTH; i++) mem_m[i] = IW'(i * 16'h0111) ^ 16'hA5A5;

    #12;
    chk("rst_instr", {16'd0, Instruction}, 32'd0);
    chk("rst_run", {31'd0, Run}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_fin", {31'd0, Finished}, 32'd0);
    chk("rst_err", {31'd0, Error}, 32'd0);
    chk("rst_count", {27'd0, Count}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge Clock);
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = mem_m[i];
    end
    @(negedge Clock);
    prog_we = 1'b0;

    // Len=0 finishes immediately without a Run pulse.
    Len = '0; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk("len0_fin", {31'd0, Finished}, 32'd1);
    chk("len0_count", {27'd0, Count}, 32'd0);
    chk("len0_busy", {31'd0, Busy}, 32'd0);
    chk("len0_run", {31'd0, Run}, 32'd0);
    @(negedge Clock);
    chk("len0_run_later", {31'd0, Run}, 32'd0);

    for (int v = 0; v < 6; v++)
      run_prog(vecs[v].len, vecs[v].exp_runs, vecs[v].exp_count, 1'b0, 1'b0, '0);

    // Timeout: Error exactly TIMEOUT cycles into WAIT.
    @(negedge Clock);
    Len = 5'd1; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    chk("to_run", {31'd0, Run}, 32'd1);
    chk("to_instr", {16'd0, Instruction}, {16'd0, mem_m[0]});
    repeat (TIMEOUT - 1) @(negedge Clock);
    chk("to_err_early", {31'd0, Error}, 32'd0);
    chk("to_busy_early", {31'd0, Busy}, 32'd1);
    @(negedge Clock);
    chk("to_err", {31'd0, Error}, 32'd1);
    chk("to_run_low", {31'd0, Run}, 32'd0);
    chk("to_busy_low", {31'd0, Busy}, 32'd0);
    chk("to_fin", {31'd0, Finished}, 32'd0);
    run_prog(1, 1, 1, 1'b0, 1'b0, '0);

    // Writes and Start pulses while Busy are dropped.
    run_prog(3, 3, 3, 1'b1, 1'b0, '0);

    // Async reset in WAIT, then a stray Done.
    @(negedge Clock);
    Len = 5'd3; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    chk("rw_run", {31'd0, Run}, 32'd1);
    #2 Resetn = 1'b0;
    #1;
    chk("rw_run_low", {31'd0, Run}, 32'd0);
    chk("rw_instr_zero", {16'd0, Instruction}, 32'd0);
    chk("rw_busy_low", {31'd0, Busy}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    @(negedge Clock);
    chk("rw_busy_after", {31'd0, Busy}, 32'd0);
    chk("rw_count_after", {27'd0, Count}, 32'd0);
    chk("rw_fin_after", {31'd0, Finished}, 32'd0);
    chk("rw_run_after", {31'd0, Run}, 32'd0);
    // Write and Start in the same IDLE cycle: the run sees the new word.
    run_prog(3, 3, 3, 1'b0, 1'b1, 16'h7E57);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
